spi_master: RTL

- SPI master that issues 32-bit register-write frames, {register number[15:0], register value[15:0]}, MSB first on MOSI.
- Captures the sample word the SPI slave returns on MISO during the same frame.
- Sits in the top-level simulation harness and the standalone board-test design, in place of the microcontroller, to drive the synth's SPI slave.
- Clocked from the internal clock; SCK is generated at or below 1/8 of the internal clock rate.

---
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_master.sv | 139 +++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - command handshake, read-back and SPI pin bundle for spi_master
interface spi_master_if;
  logic        i_CmdValid;
  logic        o_CmdReady;
  logic [15:0] i_CmdRegNumber;
  logic [15:0] i_CmdRegValue;
  logic        o_Done;
  logic [15:0] o_ReadData;
  logic        o_Busy;
  logic        o_SPI_NSS;
  logic        o_SPI_SCK;
  logic        o_SPI_MOSI;
  logic        i_SPI_MISO;

  // Seen from the SPI master block.
  modport master (
    input  i_CmdValid, i_CmdRegNumber, i_CmdRegValue, i_SPI_MISO,
    output o_CmdReady, o_Done, o_ReadData, o_Busy, o_SPI_NSS, o_SPI_SCK, o_SPI_MOSI
  );

  // Seen from whatever issues commands and plays the SPI slave.
  modport slave (
    output i_CmdValid, i_CmdRegNumber, i_CmdRegValue, i_SPI_MISO,
    input  o_CmdReady, o_Done, o_ReadData, o_Busy, o_SPI_NSS, o_SPI_SCK, o_SPI_MOSI
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - 32-bit register-write SPI master with MISO sample capture
module spi_master #(
  parameter int CLKS_PER_HALF_SCK = 4,
  parameter int LEAD_CLKS         = 4,
  parameter int GAP_CLKS          = 8
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  spi_master_if.master bus
);

  localparam int MAX_A = (CLKS_PER_HALF_SCK > LEAD_CLKS) ? CLKS_PER_HALF_SCK : LEAD_CLKS;
  localparam int MAX_C = (MAX_A > GAP_CLKS) ? MAX_A : GAP_CLKS;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_SCK - 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD_CLKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_limit;
  logic          w_last;
  logic          w_accept;
  logic          w_ready;
  logic [4:0]    r_bit;
  logic [31:0]   r_tx;
  logic [31:0]   r_rx;
  logic [15:0]   r_read;
  logic          r_done;
  logic          r_run;

  // Ready needs one clock out of reset before commands are taken.
  assign w_ready  = (r_state == S_IDLE) && r_run;
  assign w_accept = bus.i_CmdValid && w_ready;
  assign w_last   = (r_cnt == w_limit);

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; each timed state leaves when its counter reaches the limit.
  always_comb begin
    w_next  = r_state;
    w_limit = '0;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LEAD;
      S_LEAD: begin
        w_limit = LEAD_LAST;
        if (w_last) w_next = S_HIGH;
      end
      S_HIGH: begin
        w_limit = HALF_LAST;
        if (w_last) w_next = S_LOW;
      end
      S_LOW: begin
        w_limit = HALF_LAST;
        if (w_last) w_next = (r_bit == 5'd31) ? S_TRAIL : S_HIGH;
      end
      S_TRAIL: begin
        w_limit = HALF_LAST;
        if (w_last) w_next = S_GAP;
      end
      S_GAP: begin
        w_limit = GAP_LAST;
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: timing counter, shift registers, bit counter and frame-end result.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_read <= '0;
      r_done <= 1'b0;
      r_run  <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_done <= 1'b0;
      if (r_state == S_IDLE || r_state != w_next) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx  <= {bus.i_CmdRegNumber, bus.i_CmdRegValue};
            r_rx  <= '0;
            r_bit <= '0;
          end
        end
        S_LOW: begin
          // Every LOW exit is a rising-edge entry (or TRAIL entry): capture the
          // bit the slave put out after the falling edge that started this LOW.
          if (w_last) begin
            r_rx <= {r_rx[30:0], bus.i_SPI_MISO};
            if (r_bit != 5'd31) begin
              r_bit <= r_bit + 5'd1;
              r_tx  <= {r_tx[30:0], 1'b0};
            end
          end
        end
        S_TRAIL: begin
          if (w_last) begin
            r_read <= r_rx[31:16];
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_CmdReady = w_ready;
  assign bus.o_Busy     = (r_state != S_IDLE);
  assign bus.o_Done     = r_done;
  assign bus.o_ReadData = r_read;
  assign bus.o_SPI_NSS  = (r_state == S_IDLE) || (r_state == S_GAP);
  assign bus.o_SPI_SCK  = (r_state == S_HIGH);
  // MOSI follows TX[31] whenever NSS is low so it is stable across each falling edge.
  assign bus.o_SPI_MOSI = (r_state == S_LEAD || r_state == S_HIGH ||
                           r_state == S_LOW  || r_state == S_TRAIL) ? r_tx[31] : 1'b0;

endmodule
